// File: rtl/product_accumulator_8bits_if.sv
// Product-stream / result handshake bundle for product_accumulator_8bits.
// slave: the accumulator; master: the product source plus the result consumer.
`timescale 1ns/1ps
interface product_accumulator_8bits_if #(
  parameter int unsigned PROD_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned COUNT_WIDTH = 8
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [PROD_WIDTH-1:0]  in_product;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_sum;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_overflow;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/product_accumulator_8bits.sv
// Sums a packet of unsigned products (terminated by in_last) into a saturating
// accumulator and presents the packet sum/count through a one-deep result register.
`timescale 1ns/1ps
module product_accumulator_8bits #(
  parameter int unsigned PROD_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  product_accumulator_8bits_if.slave  bus
);

  logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic                   ovf_q,       ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_sum_q,   out_sum_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                   out_ovf_q,   out_ovf_d;

  logic                   accept;
  logic                   retire;
  logic [ACC_WIDTH-1:0]   add_a, add_b;
  logic [ACC_WIDTH-1:0]   ks_p, g_lvl, p_lvl, g_nxt, p_nxt;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_carry;
  logic [ACC_WIDTH-1:0]   sum_sat;
  logic [COUNT_WIDTH-1:0] cnt_sat;

  // A held result blocks every beat; a retiring result frees the slot this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = out_valid_q && bus.out_ready;

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

  // Kogge-Stone prefix adder: accumulator + zero-extended product, with carry out.
  always_comb begin
    add_a = acc_q;
    add_b = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, bus.in_product};
    ks_p  = add_a ^ add_b;
    g_lvl = add_a & add_b;
    p_lvl = ks_p;
    g_nxt = g_lvl;
    p_nxt = p_lvl;
    for (int unsigned d = 1; d < ACC_WIDTH; d = d * 2) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int unsigned i = d; i < ACC_WIDTH; i++) begin
        g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i-d]);
        p_nxt[i] = p_lvl[i] & p_lvl[i-d];
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
    add_sum   = ks_p ^ {g_lvl[ACC_WIDTH-2:0], 1'b0};
    add_carry = g_lvl[ACC_WIDTH-1];
  end

  // Saturating sum and term count for the beat being accepted.
  always_comb begin
    sum_sat = add_carry ? '1 : add_sum;
    cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state: running packet state and the one-deep result slot.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (retire) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (bus.in_last) begin
        // Last beat overrides a same-cycle retire so the slot refills without a bubble.
        out_valid_d = 1'b1;
        out_sum_d   = sum_sat;
        out_count_d = cnt_sat;
        out_ovf_d   = ovf_q | add_carry;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_sat;
        ovf_d = ovf_q | add_carry;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator_8bits.sv
// Bench for product_accumulator_8bits: two instances (16-bit and 10-bit
// accumulators) share one stimulus stream so saturation is exercised in parallel.
`timescale 1ns/1ps
module tb_product_accumulator_8bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [7:0] in_product;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  product_accumulator_8bits_if #(.PROD_WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(8)) bus16 ();
  product_accumulator_8bits_if #(.PROD_WIDTH(8), .ACC_WIDTH(10), .COUNT_WIDTH(8)) bus10 ();

  assign bus16.in_valid   = in_valid;
  assign bus16.in_product = in_product;
  assign bus16.in_last    = in_last;
  assign bus16.out_ready  = out_ready;
  assign bus10.in_valid   = in_valid;
  assign bus10.in_product = in_product;
  assign bus10.in_last    = in_last;
  assign bus10.out_ready  = out_ready;

  product_accumulator_8bits #(.PROD_WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(8)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  product_accumulator_8bits #(.PROD_WIDTH(8), .ACC_WIDTH(10), .COUNT_WIDTH(8)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10.slave)
  );

  typedef struct {
    logic [7:0]  prod;
    logic        last;
    logic [15:0] s16;
    logic [9:0]  s10;
    logic [7:0]  cnt;
    logic        o16;
    logic        o10;
  } vec_t;

  typedef struct {
    int sum;
    int cnt;
  } res_t;

  vec_t vecs[12];
  res_t rs_q[$];
  int   run_sum = 0;
  int   run_cnt = 0;
  int   retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] s16, input logic [9:0] s10,
                         input logic [7:0] cnt, input logic o16, input logic o10);
    chk({tag, " valid16"}, bus16.out_valid, 1);
    chk({tag, " valid10"}, bus10.out_valid, 1);
    chk({tag, " sum16"},   bus16.out_sum, s16);
    chk({tag, " sum10"},   bus10.out_sum, s10);
    chk({tag, " count16"}, bus16.out_count, cnt);
    chk({tag, " count10"}, bus10.out_count, cnt);
    chk({tag, " ovf16"},   bus16.out_overflow, o16);
    chk({tag, " ovf10"},   bus10.out_overflow, o10);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, {bus16.out_valid, bus10.out_valid}, 0);
    chk({tag, " sum16"}, bus16.out_sum, 0);
    chk({tag, " sum10"}, bus10.out_sum, 0);
    chk({tag, " count"}, {bus16.out_count, bus10.out_count}, 0);
    chk({tag, " ovf"},   {bus16.out_overflow, bus10.out_overflow}, 0);
  endtask

  // One randomized cycle checked against a queue-based packet model.
  task automatic rnd_cycle(input logic [7:0] prod, input logic last, input bit want,
                           output bit accepted);
    bit   exp_ready;
    bit   holding;
    res_t r;
    int   e16, e10, ec;
    out_ready  = ($urandom_range(0, 3) != 0);
    in_valid   = want && ($urandom_range(0, 3) != 0);
    in_product = prod;
    in_last    = last;
    #1;
    holding   = (rs_q.size() != 0);
    exp_ready = !holding || out_ready;
    chk("rnd in_ready",  {bus16.in_ready, bus10.in_ready}, {exp_ready, exp_ready});
    chk("rnd out_valid", {bus16.out_valid, bus10.out_valid}, {holding, holding});
    if (holding && out_ready) begin
      r   = rs_q.pop_front();
      e16 = (r.sum > 65535) ? 65535 : r.sum;
      e10 = (r.sum > 1023) ? 1023 : r.sum;
      ec  = (r.cnt > 255) ? 255 : r.cnt;
      chk("rnd sum16",  bus16.out_sum, e16);
      chk("rnd sum10",  bus10.out_sum, e10);
      chk("rnd count",  {bus16.out_count, bus10.out_count}, {ec[7:0], ec[7:0]});
      chk("rnd ovf16",  bus16.out_overflow, (r.sum > 65535) ? 1 : 0);
      chk("rnd ovf10",  bus10.out_overflow, (r.sum > 1023) ? 1 : 0);
      retired++;
    end
    accepted = in_valid && exp_ready;
    if (accepted) begin
      run_sum += int'(prod);
      run_cnt++;
      if (last) begin
        rs_q.push_back('{run_sum, run_cnt});
        run_sum = 0;
        run_cnt = 0;
      end
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int guard;
    int len;

    vecs[0]  = '{8'd15,  1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'd30,  1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'd45,  1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[3]  = '{8'd225, 1'b1, 16'd315,  10'd315,  8'd4, 1'b0, 1'b0};
    vecs[4]  = '{8'd225, 1'b1, 16'd225,  10'd225,  8'd1, 1'b0, 1'b0};
    vecs[5]  = '{8'd225, 1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[6]  = '{8'd225, 1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[7]  = '{8'd225, 1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[8]  = '{8'd225, 1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[9]  = '{8'd225, 1'b1, 16'd1125, 10'd1023, 8'd5, 1'b0, 1'b1};
    vecs[10] = '{8'd4,   1'b0, 16'd0,    10'd0,    8'd0, 1'b0, 1'b0};
    vecs[11] = '{8'd5,   1'b1, 16'd9,    10'd9,    8'd2, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_product = 8'd0; out_ready = 1'b1;
    #12;
    chk_zero("reset");
    chk("reset in_ready", {bus16.in_ready, bus10.in_ready}, 2'b11);
    @(negedge clk);
    rst = 1'b0;

    // Table: back-to-back beats with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      in_valid   = 1'b1;
      in_product = vecs[i].prod;
      in_last    = vecs[i].last;
      out_ready  = 1'b1;
      #1;
      chk($sformatf("vec%0d in_ready", i), {bus16.in_ready, bus10.in_ready}, 2'b11);
      tick();
      if (vecs[i].last)
        chk_res($sformatf("vec%0d", i), vecs[i].s16, vecs[i].s10, vecs[i].cnt,
                vecs[i].o16, vecs[i].o10);
      else
        chk($sformatf("vec%0d valid", i), {bus16.out_valid, bus10.out_valid}, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("idle valid", {bus16.out_valid, bus10.out_valid}, 0);

    // Held result stalls input; retire and refill in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_product = 8'd10; in_last = 1'b0;
    tick();
    in_product = 8'd20; in_last = 1'b1;
    tick();
    chk_res("hold0", 16'd30, 10'd30, 8'd2, 1'b0, 1'b0);
    in_product = 8'd7; in_last = 1'b1;
    #1;
    chk("hold in_ready", {bus16.in_ready, bus10.in_ready}, 0);
    tick();
    chk_res("hold1", 16'd30, 10'd30, 8'd2, 1'b0, 1'b0);
    tick();
    chk_res("hold2", 16'd30, 10'd30, 8'd2, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {bus16.in_ready, bus10.in_ready}, 2'b11);
    tick();
    chk_res("refill", 16'd7, 10'd7, 8'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("after refill valid", {bus16.out_valid, bus10.out_valid}, 0);

    // Asynchronous reset mid-packet discards the partial sum.
    in_valid = 1'b1; in_product = 8'd100; in_last = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_product = 8'd3; in_last = 1'b1;
    tick();
    chk_res("postreset", 16'd3, 10'd3, 8'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    // Term count saturates at all-ones.
    in_valid = 1'b1; in_product = 8'd1;
    for (int i = 1; i <= 300; i++) begin
      in_last = (i == 300);
      tick();
    end
    chk_res("cntsat", 16'd300, 10'd300, 8'd255, 1'b0, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();

    // Randomized packets with backpressure on both sides.
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        logic [7:0] prod;
        prod  = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 1000) begin
          rnd_cycle(prod, (b == len - 1), 1'b1, acc);
          guard++;
        end
        if (!acc) chk("rnd beat accept", 0, 1);
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (rs_q.size() != 0) rnd_cycle(8'd0, 1'b0, 1'b0, acc);
    end
    chk("rnd retired", retired, 1000);
    chk("rnd leftover", rs_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
